// File: rtl/sensor_frame_reader.sv
// Avalon-ST sink buffering framed sensor packets, drained by the host one word per CSR DATA read.
// A push is readable one edge later. Ready follows ENABLE and FULL (BACKPRESSURE=1) or ENABLE only, with overflow drops (BACKPRESSURE=0).
module sensor_frame_reader #(
  parameter int FIFO_DEPTH   = 256,
  parameter bit BACKPRESSURE = 1'b1
) (
  input  logic        clk_clk,
  input  logic        rst_reset,
  input  logic [2:0]  csr_address,
  input  logic        csr_write,
  input  logic [31:0] csr_writedata,
  input  logic [3:0]  csr_byteenable,
  input  logic        csr_read,
  output logic [31:0] csr_readdata,
  input  logic [31:0] data_in_data,
  input  logic [1:0]  data_in_empty,
  input  logic        data_in_startofpacket,
  input  logic        data_in_endofpacket,
  input  logic        data_in_valid,
  output logic        data_in_ready,
  output logic        irq
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [AW:0]   DEPTH_L = (AW+1)'(FIFO_DEPTH);
  localparam logic [AW:0]   ONE_L   = (AW+1)'(1);
  localparam logic [AW-1:0] ONE_P   = AW'(1);

  typedef enum logic [1:0] {S_IDLE, S_PACKET, S_DROP} state_t;

  state_t state, state_nxt;

  logic        enable, irq_en;
  logic        flag_ovf, flag_ferr, flag_done;
  logic [31:0] pkt_count;
  logic [15:0] pkt_len, pkt_len_inc, last_len;
  logic [1:0]  last_empty;

  logic [31:0]   mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0]   level;
  logic          fifo_empty, fifo_full;

  logic        ctrl_we, status_we, flush, beat_acc, pop;
  logic        push, ferr_set, ovf_set, pkt_complete;
  logic [31:0] rd_mux;
  logic        unused_bits;

  assign fifo_empty = (level == '0);
  assign fifo_full  = (level == DEPTH_L);
  assign ctrl_we    = csr_write && (csr_address == 3'd0);
  assign status_we  = csr_write && (csr_address == 3'd1) && csr_byteenable[2];
  assign flush      = ctrl_we && csr_byteenable[0] && csr_writedata[1];
  assign pop        = csr_read && (csr_address == 3'd2) && !fifo_empty;
  assign beat_acc   = data_in_valid && data_in_ready;

  // DROP must always drain the sender, even with ENABLE low
  assign data_in_ready = (state == S_DROP) || (enable && (!BACKPRESSURE || !fifo_full));

  assign pkt_len_inc = data_in_startofpacket ? 16'd1 :
                       (pkt_len == 16'hFFFF) ? pkt_len : pkt_len + 16'd1;

  assign unused_bits = ^{csr_writedata[31:21], csr_writedata[17:3], csr_byteenable[3], csr_byteenable[1]};

  always_ff @(posedge clk_clk) begin
    if (rst_reset) state <= S_IDLE;
    else           state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: begin
        if (beat_acc && data_in_startofpacket) begin
          if (data_in_endofpacket) state_nxt = S_IDLE;
          else                     state_nxt = fifo_full ? S_DROP : S_PACKET;
        end
      end
      S_PACKET: begin
        if (beat_acc) begin
          if (data_in_endofpacket) state_nxt = S_IDLE;
          else if (fifo_full)      state_nxt = S_DROP;
        end
      end
      S_DROP: begin
        if (beat_acc && data_in_endofpacket) state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
    // A flushed partial packet has lost its head, so its tail is discarded
    if (flush && state_nxt == S_PACKET) state_nxt = S_DROP;
  end

  always_comb begin
    push         = 1'b0;
    ferr_set     = 1'b0;
    ovf_set      = 1'b0;
    pkt_complete = 1'b0;
    if (beat_acc) begin
      case (state)
        S_IDLE: begin
          if (!data_in_startofpacket) ferr_set = 1'b1;
          else if (fifo_full)         ovf_set  = 1'b1;
          else begin
            push         = 1'b1;
            pkt_complete = data_in_endofpacket && !flush;
          end
        end
        S_PACKET: begin
          ferr_set = data_in_startofpacket;
          if (fifo_full) ovf_set = 1'b1;
          else begin
            push         = 1'b1;
            pkt_complete = data_in_endofpacket && !flush;
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    case (csr_address)
      3'd0:    rd_mux = {29'd0, irq_en, 1'b0, enable};
      3'd1:    rd_mux = {11'd0, flag_done, flag_ferr, flag_ovf, fifo_full, fifo_empty,
                         {(15-AW){1'b0}}, level};
      3'd2:    rd_mux = fifo_empty ? 32'd0 : mem[rd_ptr];
      3'd3:    rd_mux = pkt_count;
      3'd4:    rd_mux = {14'd0, last_empty, last_len};
      default: rd_mux = 32'd0;
    endcase
  end

  always_ff @(posedge clk_clk) begin
    if (push) mem[wr_ptr] <= data_in_data;
  end

  always_ff @(posedge clk_clk) begin
    if (rst_reset) begin
      enable       <= 1'b0;
      irq_en       <= 1'b0;
      flag_ovf     <= 1'b0;
      flag_ferr    <= 1'b0;
      flag_done    <= 1'b0;
      pkt_count    <= 32'd0;
      pkt_len      <= 16'd0;
      last_len     <= 16'd0;
      last_empty   <= 2'd0;
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      level        <= '0;
      irq          <= 1'b0;
      csr_readdata <= 32'd0;
    end else begin
      if (ctrl_we && csr_byteenable[0]) begin
        enable <= csr_writedata[0];
        irq_en <= csr_writedata[2];
      end
      // Set events take priority over a same-cycle write-1-to-clear
      flag_ovf  <= ovf_set      | (flag_ovf  & ~(status_we & csr_writedata[18]));
      flag_ferr <= ferr_set     | (flag_ferr & ~(status_we & csr_writedata[19]));
      flag_done <= pkt_complete | (flag_done & ~(status_we & csr_writedata[20]));
      irq       <= irq_en && flag_done;

      if (push) pkt_len <= pkt_len_inc;
      if (pkt_complete) begin
        pkt_count  <= pkt_count + 32'd1;
        last_len   <= pkt_len_inc;
        last_empty <= data_in_empty;
      end

      if (flush) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
        level  <= '0;
      end else begin
        if (push) wr_ptr <= wr_ptr + ONE_P;
        if (pop)  rd_ptr <= rd_ptr + ONE_P;
        case ({push, pop})
          2'b10:   level <= level + ONE_L;
          2'b01:   level <= level - ONE_L;
          default: level <= level;
        endcase
      end

      csr_readdata <= csr_read ? rd_mux : 32'd0;
    end
  end

endmodule

// File: tb/tb_sensor_frame_reader.sv
// Bench for sensor_frame_reader: directed scenarios plus random traffic on a depth-16 instance of each
// backpressure mode, checked every cycle against a queue-based reference model.
module tb_sensor_frame_reader;
  localparam int DEPTH = 16;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, sel;
  logic [2:0]  addr;
  logic        wr, rd, dvld, dsop, deop;
  logic [31:0] wdata, din;
  logic [3:0]  be;
  logic [1:0]  demp;

  logic        wr_a, rd_a, vld_a, wr_b, rd_b, vld_b;
  logic [31:0] rdata_a, rdata_b, rdata;
  logic        rdy_a, rdy_b, irq_a, irq_b, rdy, irq_o;

  assign wr_a  = wr & ~sel;
  assign rd_a  = rd & ~sel;
  assign vld_a = dvld & ~sel;
  assign wr_b  = wr & sel;
  assign rd_b  = rd & sel;
  assign vld_b = dvld & sel;
  assign rdata = sel ? rdata_b : rdata_a;
  assign rdy   = sel ? rdy_b : rdy_a;
  assign irq_o = sel ? irq_b : irq_a;

  sensor_frame_reader #(.FIFO_DEPTH(DEPTH), .BACKPRESSURE(1'b1)) dut_a (
    .clk_clk(clk), .rst_reset(rst),
    .csr_address(addr), .csr_write(wr_a), .csr_writedata(wdata), .csr_byteenable(be),
    .csr_read(rd_a), .csr_readdata(rdata_a),
    .data_in_data(din), .data_in_empty(demp), .data_in_startofpacket(dsop),
    .data_in_endofpacket(deop), .data_in_valid(vld_a), .data_in_ready(rdy_a), .irq(irq_a));

  sensor_frame_reader #(.FIFO_DEPTH(DEPTH), .BACKPRESSURE(1'b0)) dut_b (
    .clk_clk(clk), .rst_reset(rst),
    .csr_address(addr), .csr_write(wr_b), .csr_writedata(wdata), .csr_byteenable(be),
    .csr_read(rd_b), .csr_readdata(rdata_b),
    .data_in_data(din), .data_in_empty(demp), .data_in_startofpacket(dsop),
    .data_in_endofpacket(deop), .data_in_valid(vld_b), .data_in_ready(rdy_b), .irq(irq_b));

  // reference model
  logic [31:0] mq[$];
  bit          m_bp, m_en, m_ie, m_ovf, m_ferr, m_done, m_irq;
  bit          in_pkt, dropping;
  int          cur_len;
  logic [31:0] m_cnt;
  logic [15:0] m_llen;
  logic [1:0]  m_lemp;

  bit          last_acc, obs_rdy;
  logic [31:0] last_rd;
  int          n_chk = 0;
  int          n_bad = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    mq.delete();
    m_bp = !sel;
    {m_en, m_ie, m_ovf, m_ferr, m_done, m_irq, in_pkt, dropping} = '0;
    cur_len = 0;
    m_cnt = 0;
    m_llen = 0;
    m_lemp = 0;
  endtask

  task automatic cycle(input bit v, input bit s, input bit e, input logic [1:0] emp,
                       input logic [31:0] dat, input bit r, input bit w,
                       input logic [2:0] a, input logic [31:0] wd, input logic [3:0] b);
    logic [31:0] exp_rd;
    bit exp_rdy, acc, flush, full, complete, set_ovf, set_ferr, irq_nxt;
    int sz;
    dvld = v; dsop = s; deop = e; demp = emp; din = dat;
    rd = r; wr = w; addr = a; wdata = wd; be = b;
    #1;
    sz      = mq.size();
    full    = (sz == DEPTH);
    exp_rdy = dropping || (m_en && (!m_bp || !full));
    obs_rdy = rdy;
    chk("ready", rdy, exp_rdy);
    acc      = v && exp_rdy;
    last_acc = acc;
    case (a)
      3'd0:    exp_rd = {29'd0, m_ie, 1'b0, m_en};
      3'd1:    exp_rd = {11'd0, m_done, m_ferr, m_ovf, full, sz == 0, 16'(sz)};
      3'd2:    exp_rd = (sz > 0) ? mq[0] : 32'd0;
      3'd3:    exp_rd = m_cnt;
      3'd4:    exp_rd = {14'd0, m_lemp, m_llen};
      default: exp_rd = 32'd0;
    endcase
    flush    = w && a == 3'd0 && b[0] && wd[1];
    irq_nxt  = m_ie && m_done;
    complete = 0;
    set_ovf  = 0;
    set_ferr = 0;
    if (acc) begin
      if (dropping) begin
        if (e) dropping = 0;
      end else if (!in_pkt && !s) begin
        set_ferr = 1;
      end else begin
        if (in_pkt && s) set_ferr = 1;
        if (s) cur_len = 0;
        if (full) begin
          set_ovf  = 1;
          in_pkt   = 0;
          dropping = !e;
        end else begin
          mq.push_back(dat);
          if (cur_len < 65535) cur_len++;
          if (e) begin
            in_pkt   = 0;
            complete = !flush;
          end else in_pkt = 1;
        end
      end
    end
    if (r && a == 3'd2 && sz > 0) void'(mq.pop_front());
    if (complete) begin
      m_cnt  = m_cnt + 1;
      m_llen = 16'(cur_len);
      m_lemp = emp;
    end
    if (w && a == 3'd0 && b[0]) begin
      m_en = wd[0];
      m_ie = wd[2];
    end
    if (w && a == 3'd1 && b[2]) begin
      if (wd[18]) m_ovf = 0;
      if (wd[19]) m_ferr = 0;
      if (wd[20]) m_done = 0;
    end
    m_ovf  |= set_ovf;
    m_ferr |= set_ferr;
    m_done |= complete;
    if (flush) begin
      mq.delete();
      if (in_pkt) begin
        in_pkt   = 0;
        dropping = 1;
      end
    end
    m_irq = irq_nxt;
    @(posedge clk);
    @(negedge clk);
    dvld = 0; rd = 0; wr = 0;
    if (r) chk("rdata", rdata, exp_rd);
    chk("irq", irq_o, m_irq);
    last_rd = rdata;
  endtask

  task automatic idle();
    cycle(0, 0, 0, 2'd0, 32'd0, 0, 0, 3'd0, 32'd0, 4'h0);
  endtask

  task automatic wr_csr(input logic [2:0] a, input logic [31:0] d);
    cycle(0, 0, 0, 2'd0, 32'd0, 0, 1, a, d, 4'hF);
  endtask

  task automatic rd_csr(input logic [2:0] a, output logic [31:0] d);
    cycle(0, 0, 0, 2'd0, 32'd0, 1, 0, a, 32'd0, 4'h0);
    d = last_rd;
  endtask

  task automatic send(input logic [31:0] dat, input bit s, input bit e, input logic [1:0] emp);
    bit ok = 0;
    for (int k = 0; k < 40 && !ok; k++) begin
      cycle(1, s, e, emp, dat, 0, 0, 3'd0, 32'd0, 4'h0);
      ok = last_acc;
    end
    chk("send_accepted", 32'(ok), 32'd1);
  endtask

  task automatic do_reset(input bit which);
    {dvld, dsop, deop, rd, wr} = '0;
    {din, wdata, demp, be, addr} = '0;
    sel = which;
    rst = 1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 0;
    model_reset();
    #1;
    chk("rst_ready", rdy, 0);
    chk("rst_irq", irq_o, 0);
    chk("rst_rdata", rdata, 0);
  endtask

  task automatic rand_run(input int n);
    int gpos = 0;
    int glen = 4;
    for (int i = 0; i < n; i++) begin
      bit v, s, e, r, w;
      logic [2:0] a;
      logic [31:0] wd;
      logic [3:0] b;
      int op;
      v = ($urandom % 3) != 0;
      s = (gpos == 0);
      e = (gpos == glen - 1);
      if ($urandom % 20 == 0) s = !s;
      r = 0; w = 0; a = 3'd0; wd = 0; b = 4'hF;
      op = int'($urandom % 16);
      if (op < 6) begin r = 1; a = 3'd2; end
      else if (op < 8) begin r = 1; a = 3'($urandom); end
      else if (op == 8) begin
        w = 1;
        wd = {29'd0, 1'($urandom), ($urandom % 8) == 0, ($urandom % 8) != 0};
      end else if (op == 9) begin
        w = 1; a = 3'd1; wd = $urandom & 32'h001C0000; b = 4'($urandom);
      end else if (op == 10) begin
        w = 1; a = 3'($urandom_range(2, 7)); wd = $urandom;
      end
      cycle(v, s, e, 2'($urandom), $urandom, r, w, a, wd, b);
      if (last_acc) begin
        if (e) begin gpos = 0; glen = $urandom_range(1, 24); end
        else gpos++;
      end
    end
  endtask

  initial begin
    #600000;
    $display("FAIL watchdog t=%0t", $time);
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [31:0] d;
    int k;
    rst = 1;
    sel = 0;

    // BACKPRESSURE=1 instance
    do_reset(0);
    rd_csr(3'd1, d);
    chk("rst_status", d, 32'h0001_0000);
    wr_csr(3'd0, 32'h1);
    for (int i = 1; i <= 4; i++) send(32'(i), i == 1, i == 4, (i == 4) ? 2'd2 : 2'd0);
    rd_csr(3'd1, d); chk("a_level", d & 32'hFFFF, 4);
    rd_csr(3'd3, d); chk("a_pkt_count", d, 1);
    rd_csr(3'd4, d); chk("a_last_len", d, 32'h0002_0004);
    for (int i = 1; i <= 4; i++) begin
      rd_csr(3'd2, d);
      chk("a_data", d, 32'(i));
    end
    rd_csr(3'd2, d); chk("a_data_empty", d, 0);
    rd_csr(3'd1, d); chk("a_empty_bit", (d >> 16) & 1, 1);

    wr_csr(3'd0, 32'h5);
    idle();
    chk("irq_on", irq_o, 1);
    wr_csr(3'd1, 32'h0010_0000);
    idle();
    chk("irq_off", irq_o, 0);

    wr_csr(3'd0, 32'h1);
    k = 0;
    for (int c = 0; c < 40 && k < 16; c++) begin
      cycle(1, k == 0, 0, 2'd0, 32'h100 + 32'(k), 0, 0, 3'd0, 32'd0, 4'h0);
      if (last_acc) k++;
    end
    chk("bp_accepted16", k, 16);
    cycle(1, 0, 0, 2'd0, 32'h100 + 32'(k), 0, 0, 3'd0, 32'd0, 4'h0);
    chk("bp_ready_low", 32'(obs_rdy), 0);
    for (int c = 0; c < 40 && k < 20; c++) begin
      cycle(1, 0, k == 19, 2'd0, 32'h100 + 32'(k), 1, 0, 3'd2, 32'd0, 4'h0);
      if (last_acc) k++;
    end
    rd_csr(3'd4, d); chk("bp_last_len", d, 20);
    rd_csr(3'd1, d); chk("bp_no_ovf", (d >> 18) & 1, 0);
    rd_csr(3'd3, d); chk("bp_pkt_count", d, 2);

    // BACKPRESSURE=0 instance
    do_reset(1);
    wr_csr(3'd0, 32'h1);
    send(32'hBAD, 0, 0, 2'd0);
    send(32'hA1, 1, 0, 2'd0);
    send(32'hA2, 0, 0, 2'd0);
    send(32'hB1, 1, 0, 2'd0);
    send(32'hB2, 0, 1, 2'd1);
    rd_csr(3'd1, d);
    chk("fe_flag", (d >> 19) & 1, 1);
    chk("fe_level", d & 32'hFFFF, 4);
    rd_csr(3'd3, d); chk("fe_pkt_count", d, 1);
    rd_csr(3'd4, d); chk("fe_last_len", d, 32'h0001_0002);
    rd_csr(3'd2, d); chk("fe_head", d, 32'hA1);

    cycle(1, 1, 1, 2'd0, 32'hC1, 1, 0, 3'd2, 32'd0, 4'h0);
    chk("pp_old_head", last_rd, 32'hA2);
    rd_csr(3'd1, d); chk("pp_level", d & 32'hFFFF, 3);

    send(32'hD1, 1, 0, 2'd0);
    wr_csr(3'd0, 32'h3);
    rd_csr(3'd1, d); chk("fl_level", d & 32'hFFFF, 0);
    send(32'hD2, 0, 0, 2'd0);
    send(32'hD3, 0, 1, 2'd0);
    rd_csr(3'd1, d); chk("fl_drop_level", d & 32'hFFFF, 0);
    rd_csr(3'd3, d); chk("fl_pkt_count", d, 2);
    send(32'hE1, 1, 1, 2'd0);
    rd_csr(3'd1, d); chk("fl_after_level", d & 32'hFFFF, 1);

    wr_csr(3'd0, 32'h3);
    for (int i = 0; i < 20; i++) send(32'h200 + 32'(i), i == 0, i == 19, 2'd0);
    rd_csr(3'd1, d);
    chk("ov_level", d & 32'hFFFF, 16);
    chk("ov_flag", (d >> 18) & 1, 1);
    rd_csr(3'd3, d); chk("ov_pkt_count", d, 3);
    rd_csr(3'd2, d); chk("ov_head0", d, 32'h200);
    rd_csr(3'd2, d); chk("ov_head1", d, 32'h201);
    send(32'h300, 1, 0, 2'd0);
    send(32'h301, 0, 1, 2'd0);
    rd_csr(3'd3, d); chk("ov_next_pkt", d, 4);

    rand_run(2000);
    do_reset(0);
    wr_csr(3'd0, 32'h1);
    rand_run(2000);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end
endmodule

// File: doc/sensor_frame_reader.md
# sensor_frame_reader

Avalon-ST sink and CSR-readable frame buffer that consumes the packet stream produced by `sensor_interface` (`data_out_*`) and lets the host drain it word by word over an Avalon-MM CSR slave. It stores complete packets in a FIFO and checks packet framing. It reports fill level, overflow and framing errors, and raises an interrupt when a packet completes. It sits between the sensor interface and the host, and is the reader for the sensor data stream.

## Interface
- `FIFO_DEPTH`, 256: FIFO depth in 32-bit words; power of two, 16..4096.
- `BACKPRESSURE`, 1: 1 deasserts ready when the FIFO is full; 0 keeps ready high and drops words on full.
- `clk_clk`  in  1  single clock; all logic rising-edge.
- `rst_reset`  in  1  synchronous, active-high reset.
- `csr_address`  in  3  register select.
- `csr_write`  in  1  write strobe.
- `csr_writedata`  in  32  write data.
- `csr_byteenable`  in  4  byte lanes; a disabled lane leaves that byte of the register unchanged.
- `csr_read`  in  1  read strobe.
- `csr_readdata`  out  32  read data, read latency 1.
- `data_in_data`  in  32  stream word.
- `data_in_empty`  in  2  unused bytes in the EOP word.
- `data_in_startofpacket`  in  1  SOP.
- `data_in_endofpacket`  in  1  EOP.
- `data_in_valid`  in  1  beat valid.
- `data_in_ready`  out  1  sink ready, ready latency 0.
- `irq`  out  1  level interrupt.

## Operation
- A beat is accepted when `data_in_valid && data_in_ready`.
- Registers:
  - 0 CTRL, RW:
    - bit0 ENABLE.
    - bit1 FLUSH: self-clearing and reads 0.
    - bit2 IRQ_EN.
  - 1 STATUS:
    - [15:0] fill level.
    - bit16 EMPTY.
    - bit17 FULL.
    - bit18 OVERFLOW: sticky, W1C.
    - bit19 FRAME_ERR: sticky, W1C.
    - bit20 PKT_DONE: sticky, W1C.
    - Other bits read 0 and ignore writes.
  - 2 DATA, RO: a read returns the head word and pops it. A read when empty returns 0 and does not pop.
  - 3 PKT_COUNT, RO: 32-bit count of completed packets; wraps at 2^32. Cleared by reset only.
  - 4 LAST_LEN, RO:
    - [15:0] word count of the last completed packet.
    - [17:16] its `empty`.
  - 5–7: read 0, writes ignored.
- `data_in_ready`:
  - Equals `ENABLE && !FULL` when BACKPRESSURE=1.
  - Equals `ENABLE` when BACKPRESSURE=0.
  - Forced to 1 in state DROP, independent of ENABLE.
- FSM:
  - **IDLE**:
    - Accepted beat with SOP: push it. Go to PACKET, or stay in IDLE if EOP is also set (single-word packet).
    - Accepted beat without SOP: discard it, set FRAME_ERR, stay in IDLE.
  - **PACKET**:
    - Accepted beat: push it. On EOP, complete the packet and go to IDLE.
    - SOP while in PACKET: set FRAME_ERR. The beat is stored as the start of a new packet; the truncated packet is not counted.
    - Full and a beat is accepted (BACKPRESSURE=0 only): drop the word, set OVERFLOW, go to DROP. If that beat carries EOP, go to IDLE instead.
  - **DROP**: discard beats until an accepted EOP, then go to IDLE. Dropped packets do not update PKT_COUNT, LAST_LEN or PKT_DONE.
- Completing a packet does all of the following:
  - PKT_COUNT+1.
  - LAST_LEN ← words in the packet (16-bit counter, saturates at 0xFFFF) and `empty`.
  - PKT_DONE set.
- `irq` = IRQ_EN && PKT_DONE, registered.
- FLUSH:
  - Empties the FIFO in the cycle after the write.
  - If the FSM is in PACKET, it moves to DROP.
  - Sticky flags are unaffected.
- ENABLE=0 with the FSM in PACKET: ready is low (stall); state is held.

## Timing
- Reset values:
  - `data_in_ready`=0, `csr_readdata`=0, `irq`=0.
  - CTRL=0, all flags 0, PKT_COUNT=0, LAST_LEN=0.
  - FIFO empty, FSM in IDLE.
- CSR read: `csr_readdata` is valid in the cycle after `csr_read`. A DATA pop commits at the same edge the read is sampled.
- Push-to-readable latency: a word accepted at edge N is visible in the fill level and poppable from edge N+1.
- Push and pop in the same cycle: the fill level is unchanged; the pop returns the old head.
- Pop on a 1-word FIFO with a simultaneous push: returns the old word; the new word becomes head.
- FLUSH in the same cycle as a push or pop: FLUSH wins and the level becomes 0.
- W1C in the same cycle as a new set event: the set wins and the flag stays 1.
- FULL is asserted when level == FIFO_DEPTH; pointers wrap modulo FIFO_DEPTH.

## Test plan
- Reset, then ENABLE=1; send a 4-word packet 0x1..0x4 with SOP on word 1, EOP and empty=2 on word 4 -> STATUS level=4, PKT_COUNT=1, LAST_LEN=0x00020004. Four DATA reads return 1,2,3,4; a fifth read returns 0 with EMPTY=1.
- IRQ_EN=1 and one packet completes -> `irq`=1 one cycle after PKT_DONE is set. Write 0x00100000 to STATUS -> `irq`=0.
- BACKPRESSURE=1, FIFO_DEPTH=16, 20-word packet with no reads -> ready drops after 16 accepted words. After 4 DATA reads the packet completes with LAST_LEN=20 and OVERFLOW=0.
- BACKPRESSURE=0, depth 16, 20-word packet -> 16 words stored, OVERFLOW=1, PKT_COUNT unchanged. The next 2-word packet is accepted after 2 pops.
- Beat without SOP in IDLE, then SOP inside an open packet -> FRAME_ERR=1. The first beat is absent from the FIFO; PKT_COUNT counts only the second packet.
- Simultaneous push and DATA pop at level 3 -> level stays 3. FLUSH mid-packet -> level 0 and the rest of the packet is discarded until EOP.
